// File: rtl/key_sched_ctrl_dec_pkg.sv
// Shared types and constants for the decryption key-schedule controller.
// State encoding and AES-128 sizing are fixed here so the bench and RTL agree.
package key_sched_ctrl_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        READY  = 2'd3
    } state_t;

    localparam logic [3:0] AES_NR    = 4'd10;
    localparam int         AES_KEY_W = 128;

endpackage

// File: rtl/key_sched_ctrl_dec_if.sv
// Host key handshake plus the drive lines toward key_generator_dec.
// The master side is the host and the generator; the slave side is the controller.
interface key_sched_ctrl_dec_if;
    import key_sched_ctrl_dec_pkg::*;

    logic [AES_KEY_W-1:0] key_in;
    logic                 key_valid;
    logic                 key_ready;
    logic                 pipe_empty;
    logic [AES_KEY_W-1:0] kg_key;
    logic                 kg_en;
    logic [3:0]           kg_round_cnt;
    logic                 keys_ready;
    logic                 busy;

    modport master (
        output key_in, key_valid, pipe_empty,
        input  key_ready, kg_key, kg_en, kg_round_cnt, keys_ready, busy
    );

    modport slave (
        input  key_in, key_valid, pipe_empty,
        output key_ready, kg_key, kg_en, kg_round_cnt, keys_ready, busy
    );

endinterface

// File: rtl/key_sched_ctrl_dec.sv
// Sequences key_generator_dec through k0 load and rounds 1..NUM_ROUNDS.
// Re-keying is only allowed from IDLE, or from READY once the pipeline has drained.
//
// state  | meaning
// IDLE   | no valid keys; waiting for the first key
// LOAD   | generator writes k0 from the held key
// EXPAND | generator computes round key k[round_cnt]
// READY  | k0..k10 valid and stable; re-key when pipe_empty
module key_sched_ctrl_dec
    import key_sched_ctrl_dec_pkg::*;
#(
    parameter logic [3:0] NUM_ROUNDS = AES_NR
) (
    input logic                 clk,
    input logic                 rst,
    key_sched_ctrl_dec_if.slave bus
);

    state_t               state;
    logic [3:0]           round_cnt;
    logic [AES_KEY_W-1:0] key_q;
    logic                 accept;

    assign bus.key_ready = (state == IDLE) | ((state == READY) & bus.pipe_empty);
    assign accept        = bus.key_valid & bus.key_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            key_q     <= '0;
        end else if (round_cnt > NUM_ROUNDS) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        key_q     <= bus.key_in;
                        state     <= LOAD;
                        round_cnt <= 4'd0;
                    end
                end
                LOAD: begin
                    state     <= EXPAND;
                    round_cnt <= 4'd1;
                end
                EXPAND: begin
                    // Counter parks at NUM_ROUNDS in READY; it is only reused after the next accept.
                    if (round_cnt == 4'd0) begin
                        state     <= IDLE;
                        round_cnt <= 4'd0;
                    end else if (round_cnt == NUM_ROUNDS) begin
                        state <= READY;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    round_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.kg_key       = key_q;
    assign bus.kg_en        = (state == LOAD) | (state == EXPAND);
    assign bus.kg_round_cnt = (state == EXPAND) ? round_cnt : 4'd0;
    assign bus.keys_ready   = (state == READY);
    assign bus.busy         = (state == LOAD) | (state == EXPAND);

endmodule

// File: tb/tb_key_sched_ctrl_dec.sv
// Directed bench: controller driving a behavioural AES-128 key expansion model,
// checking sequencing, handshake gating, reset and the resulting round keys.
module tb_key_sched_ctrl_dec;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    key_sched_ctrl_dec_if bus ();

    key_sched_ctrl_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sbox [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon(r), 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Generator model: k0 reloaded on every en cycle, k[r] built from k[r-1].
    logic [127:0] rk [0:10];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else if (bus.kg_en) begin
            rk[0] <= bus.kg_key;
            if (bus.kg_round_cnt != 4'd0 && bus.kg_round_cnt <= 4'd10)
                rk[bus.kg_round_cnt] <= next_rk(rk[bus.kg_round_cnt - 4'd1], bus.kg_round_cnt);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Entered at the LOAD sample point; leaves at the first READY sample point.
    task automatic expand_check(input string tag, input int pulse_at,
                                input logic [127:0] pulse_key, input logic [127:0] keep_key);
        for (int i = 0; i <= 10; i++) begin
            chk1($sformatf("%s_en%0d", tag, i), bus.kg_en, 1'b1);
            chk4($sformatf("%s_cnt%0d", tag, i), bus.kg_round_cnt, 4'(i));
            chk1($sformatf("%s_busy%0d", tag, i), bus.busy, 1'b1);
            chk1($sformatf("%s_krdy%0d", tag, i), bus.keys_ready, 1'b0);
            chk1($sformatf("%s_kin_rdy%0d", tag, i), bus.key_ready, 1'b0);
            chk128($sformatf("%s_key%0d", tag, i), bus.kg_key, keep_key);
            if (i == pulse_at) begin
                bus.key_in    = pulse_key;
                bus.key_valid = 1'b1;
            end
            tick();
            if (i == pulse_at) bus.key_valid = 1'b0;
        end
        chk1({tag, "_ready"}, bus.keys_ready, 1'b1);
        chk1({tag, "_en_off"}, bus.kg_en, 1'b0);
        chk1({tag, "_busy_off"}, bus.busy, 1'b0);
        chk4({tag, "_cnt_off"}, bus.kg_round_cnt, 4'd0);
    endtask

    initial begin
        rst            = 1'b0;
        bus.key_in     = '0;
        bus.key_valid  = 1'b0;
        bus.pipe_empty = 1'b1;
        tick();
        chk1("rst_en", bus.kg_en, 1'b0);
        chk4("rst_cnt", bus.kg_round_cnt, 4'd0);
        chk1("rst_krdy", bus.keys_ready, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_kin_rdy", bus.key_ready, 1'b1);
        chk128("rst_key", bus.kg_key, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk1("idle_krdy", bus.keys_ready, 1'b0);

        // Test 1: IDLE accepts regardless of pipe_empty
        bus.pipe_empty = 1'b0;
        bus.key_in     = K1;
        bus.key_valid  = 1'b1;
        #1;
        chk1("t1_kin_rdy", bus.key_ready, 1'b1);
        tick();
        bus.key_valid = 1'b0;
        expand_check("t1", -1, '0, K1);
        chk128("t1_k10", rk[10], K1_R10);

        // Test 2
        bus.pipe_empty = 1'b1;
        bus.key_in     = K2;
        bus.key_valid  = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        expand_check("t2", -1, '0, K2);
        chk128("t2_k1", rk[1], K2_R1);
        chk128("t2_k10", rk[10], K2_R10);

        // Test 3: re-key held off while the pipeline is busy
        bus.pipe_empty = 1'b0;
        bus.key_in     = K1;
        bus.key_valid  = 1'b1;
        #1;
        chk1("t3_kin_rdy_blk", bus.key_ready, 1'b0);
        repeat (3) tick();
        chk1("t3_krdy_hold", bus.keys_ready, 1'b1);
        chk1("t3_busy_hold", bus.busy, 1'b0);
        chk128("t3_key_hold", bus.kg_key, K2);
        chk128("t3_k10_hold", rk[10], K2_R10);
        bus.pipe_empty = 1'b1;
        #1;
        chk1("t3_kin_rdy", bus.key_ready, 1'b1);
        tick();
        bus.key_valid = 1'b0;
        chk1("t3_krdy_drop", bus.keys_ready, 1'b0);
        expand_check("t3", -1, '0, K1);
        chk128("t3_k10", rk[10], K1_R10);

        // Test 4: valid pulse during EXPAND is ignored
        bus.key_in    = K2;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        expand_check("t4", 5, K1, K2);
        chk128("t4_key", bus.kg_key, K2);
        chk128("t4_k10", rk[10], K2_R10);

        // Test 5: async reset mid-expansion
        bus.key_in    = K2;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        repeat (6) tick();
        chk4("t5_pre_cnt", bus.kg_round_cnt, 4'd6);
        rst = 1'b0;
        #1;
        chk1("t5_en", bus.kg_en, 1'b0);
        chk4("t5_cnt", bus.kg_round_cnt, 4'd0);
        chk1("t5_busy", bus.busy, 1'b0);
        chk1("t5_krdy", bus.keys_ready, 1'b0);
        chk1("t5_kin_rdy", bus.key_ready, 1'b1);
        chk128("t5_key", bus.kg_key, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();
        chk1("t5_idle_krdy", bus.keys_ready, 1'b0);
        chk1("t5_idle_en", bus.kg_en, 1'b0);
        bus.key_in    = K1;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        expand_check("t5", -1, '0, K1);
        chk128("t5_k10", rk[10], K1_R10);

        // Test 6: valid held high from IDLE, exactly one accept
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst            = 1'b1;
        bus.pipe_empty = 1'b0;
        bus.key_in     = K2;
        bus.key_valid  = 1'b1;
        tick();
        bus.key_in = K1;
        expand_check("t6", -1, '0, K2);
        repeat (3) tick();
        chk1("t6_busy_off", bus.busy, 1'b0);
        chk1("t6_krdy", bus.keys_ready, 1'b1);
        chk128("t6_key", bus.kg_key, K2);
        chk128("t6_k10", rk[10], K2_R10);
        bus.key_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
